// File: rtl/tri_pkg.sv
// ---------------------------------------------------------------------------
// tri_pkg: shared widths, vertex-index encoding and triangle record. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package tri_pkg;

  localparam int SCR_XW = 11;
  localparam int SCR_YW = 10;
  localparam int AREA_W = SCR_XW + SCR_YW + 3;

  typedef enum logic [1:0] {
    VIDX_A = 2'd0,
    VIDX_B = 2'd1,
    VIDX_C = 2'd2
  } vidx_t;

  typedef struct packed {
    logic [SCR_XW-1:0] ax;
    logic [SCR_YW-1:0] ay;
    logic [SCR_XW-1:0] bx;
    logic [SCR_YW-1:0] by;
    logic [SCR_XW-1:0] cx;
    logic [SCR_YW-1:0] cy;
    logic [SCR_XW-1:0] xmin;
    logic [SCR_XW-1:0] xmax;
    logic [SCR_YW-1:0] ymin;
    logic [SCR_YW-1:0] ymax;
    logic [AREA_W-1:0] area2;
  } tri_t;

endpackage

`default_nettype wire

// File: rtl/tri_fifo.sv
// ---------------------------------------------------------------------------
// tri_fifo: first-word-fall-through FIFO, power-of-two depth. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tri_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic         clk_in,
  input  logic         rst_in,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         rd_en,
  output logic [W-1:0] rd_data,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic [W-1:0] mem [DEPTH];
  logic         do_wr;
  logic         do_rd;

  // Extra pointer MSB distinguishes full from empty when the addresses match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_rd = rd_en && !empty;
  assign do_wr = wr_en && (!full || do_rd);

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + (AW + 1)'(1);
      if (do_rd) rd_ptr <= rd_ptr + (AW + 1)'(1);
    end
  end

  always_ff @(posedge clk_in) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

`default_nettype wire

// File: rtl/tri_assemble.sv
// ---------------------------------------------------------------------------
// tri_assemble: groups vertices into triangles, computes bbox and 2x signed
// area, buffers results. Define TRI_CULL_EN to drop area2 <= 0. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tri_assemble
  import tri_pkg::*;
#(
  parameter int XW    = SCR_XW,
  parameter int YW    = SCR_YW,
  parameter int DEPTH = 16
) (
  input  logic          clk_in,
  input  logic          rst_in,
  input  logic          frame_start,
  input  logic          vtx_valid,
  input  logic [XW-1:0] vtx_x,
  input  logic [YW-1:0] vtx_y,
  output logic          tri_valid,
  input  logic          tri_ready,
  output tri_t          tri_out,
  output logic [15:0]   tri_count,
  output logic          overflow
);

  localparam int DXW = XW + 1;
  localparam int DYW = YW + 1;
  localparam int PW  = XW + YW + 2;

  vidx_t vidx, vidx_nxt, vidx_cur;
  logic  cap_a, cap_b, cap_c;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) vidx <= VIDX_A;
    else         vidx <= vidx_nxt;
  end

  // A vertex arriving with frame_start is A of the new frame.
  always_comb begin
    vidx_nxt = vidx;
    cap_a    = 1'b0;
    cap_b    = 1'b0;
    cap_c    = 1'b0;
    vidx_cur = frame_start ? VIDX_A : vidx;
    if (frame_start) vidx_nxt = VIDX_A;
    if (vtx_valid) begin
      case (vidx_cur)
        VIDX_A: begin cap_a = 1'b1; vidx_nxt = VIDX_B; end
        VIDX_B: begin cap_b = 1'b1; vidx_nxt = VIDX_C; end
        VIDX_C: begin cap_c = 1'b1; vidx_nxt = VIDX_A; end
        default: vidx_nxt = VIDX_A;
      endcase
    end
  end

  logic [XW-1:0] ax_q, bx_q, cx_q;
  logic [YW-1:0] ay_q, by_q, cy_q;
  logic          launch;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      ax_q   <= '0;
      ay_q   <= '0;
      bx_q   <= '0;
      by_q   <= '0;
      cx_q   <= '0;
      cy_q   <= '0;
      launch <= 1'b0;
    end else begin
      launch <= cap_c;
      if (cap_a) begin ax_q <= vtx_x; ay_q <= vtx_y; end
      if (cap_b) begin bx_q <= vtx_x; by_q <= vtx_y; end
      if (cap_c) begin cx_q <= vtx_x; cy_q <= vtx_y; end
    end
  end

  // P1: bounding box and edge vectors relative to A
  tri_t                  p1_w;
  logic signed [DXW-1:0] dbx_w, dcx_w;
  logic signed [DYW-1:0] dby_w, dcy_w;

  assign dbx_w = $signed({1'b0, bx_q}) - $signed({1'b0, ax_q});
  assign dcx_w = $signed({1'b0, cx_q}) - $signed({1'b0, ax_q});
  assign dby_w = $signed({1'b0, by_q}) - $signed({1'b0, ay_q});
  assign dcy_w = $signed({1'b0, cy_q}) - $signed({1'b0, ay_q});

  always_comb begin
    p1_w      = '0;
    p1_w.ax   = ax_q;
    p1_w.ay   = ay_q;
    p1_w.bx   = bx_q;
    p1_w.by   = by_q;
    p1_w.cx   = cx_q;
    p1_w.cy   = cy_q;
    p1_w.xmin = (ax_q < bx_q) ? ax_q : bx_q;
    p1_w.xmax = (ax_q > bx_q) ? ax_q : bx_q;
    p1_w.ymin = (ay_q < by_q) ? ay_q : by_q;
    p1_w.ymax = (ay_q > by_q) ? ay_q : by_q;
    if (cx_q < p1_w.xmin) p1_w.xmin = cx_q;
    if (cx_q > p1_w.xmax) p1_w.xmax = cx_q;
    if (cy_q < p1_w.ymin) p1_w.ymin = cy_q;
    if (cy_q > p1_w.ymax) p1_w.ymax = cy_q;
  end

  logic                  p1_valid, p2_valid, p3_valid;
  tri_t                  p1_tri, p2_tri, p3_tri, p3_w;
  logic signed [DXW-1:0] p1_dbx, p1_dcx;
  logic signed [DYW-1:0] p1_dby, p1_dcy;
  logic signed [PW-1:0]  p2_m0, p2_m1;
  logic signed [AREA_W-1:0] area_w;

  // Operands are widened to the full product width before multiplying.
  assign area_w = AREA_W'(p2_m0) - AREA_W'(p2_m1);

  always_comb begin
    p3_w       = p2_tri;
    p3_w.area2 = area_w;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      p1_valid <= 1'b0;
      p2_valid <= 1'b0;
      p3_valid <= 1'b0;
      p1_tri   <= '0;
      p2_tri   <= '0;
      p3_tri   <= '0;
      p1_dbx   <= '0;
      p1_dcx   <= '0;
      p1_dby   <= '0;
      p1_dcy   <= '0;
      p2_m0    <= '0;
      p2_m1    <= '0;
    end else begin
      p1_valid <= launch;
      p1_tri   <= p1_w;
      p1_dbx   <= dbx_w;
      p1_dcx   <= dcx_w;
      p1_dby   <= dby_w;
      p1_dcy   <= dcy_w;
      p2_valid <= p1_valid;
      p2_tri   <= p1_tri;
      p2_m0    <= PW'(p1_dbx) * PW'(p1_dcy);
      p2_m1    <= PW'(p1_dcx) * PW'(p1_dby);
      p3_valid <= p2_valid;
      p3_tri   <= p3_w;
    end
  end

  logic keep;
`ifdef TRI_CULL_EN
  assign keep = ($signed(p3_tri.area2) > 0);
`else
  assign keep = 1'b1;
`endif

  logic fifo_full, fifo_empty, pop, push, drop;

  assign tri_valid = !fifo_empty;
  assign pop       = tri_valid && tri_ready;
  assign push      = p3_valid && keep && (!fifo_full || pop);
  assign drop      = p3_valid && keep && fifo_full && !pop;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      tri_count <= '0;
      overflow  <= 1'b0;
    end else if (frame_start) begin
      tri_count <= push ? 16'd1 : 16'd0;
      overflow  <= drop;
    end else begin
      if (push && (tri_count != 16'hFFFF)) tri_count <= tri_count + 16'd1;
      if (drop) overflow <= 1'b1;
    end
  end

  tri_fifo #(
    .W     ($bits(tri_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .wr_en   (push),
    .wr_data (p3_tri),
    .rd_en   (pop),
    .rd_data (tri_out),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

endmodule

`default_nettype wire

// File: tb/tb_tri_assemble.sv
// ---------------------------------------------------------------------------
// tb_tri_assemble: directed and randomized checks against a triangle-level
// reference model. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_tri_assemble;
  import tri_pkg::*;

  localparam int XW    = SCR_XW;
  localparam int YW    = SCR_YW;
  localparam int DEPTH = 16;

  logic          clk_in      = 1'b0;
  logic          rst_in      = 1'b1;
  logic          frame_start = 1'b0;
  logic          vtx_valid   = 1'b0;
  logic [XW-1:0] vtx_x       = '0;
  logic [YW-1:0] vtx_y       = '0;
  logic          tri_ready   = 1'b0;
  logic          tri_valid;
  tri_t          tri_out;
  logic [15:0]   tri_count;
  logic          overflow;

  tri_assemble #(.XW(XW), .YW(YW), .DEPTH(DEPTH)) dut (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .frame_start (frame_start),
    .vtx_valid   (vtx_valid),
    .vtx_x       (vtx_x),
    .vtx_y       (vtx_y),
    .tri_valid   (tri_valid),
    .tri_ready   (tri_ready),
    .tri_out     (tri_out),
    .tri_count   (tri_count),
    .overflow    (overflow)
  );

  always #5 clk_in = ~clk_in;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Reference model: triangles in flight keyed by the edge they reach the FIFO.
  typedef struct { tri_t t; int due; } pend_t;
  tri_t  mq[$];
  pend_t pend[$];
  int    cyc  = 0;
  int    nv   = 0;
  int    mcnt = 0;
  bit    movf = 0;
  int    vx[3];
  int    vy[3];

  function automatic int min3(int a, int b, int c);
    int m = a;
    if (b < m) m = b;
    if (c < m) m = c;
    return m;
  endfunction

  function automatic int max3(int a, int b, int c);
    int m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

  function automatic tri_t make_tri(int ax, int ay, int bx, int by, int cx, int cy);
    tri_t t;
    int   a;
    a       = (bx - ax) * (cy - ay) - (cx - ax) * (by - ay);
    t.ax    = XW'(ax);
    t.ay    = YW'(ay);
    t.bx    = XW'(bx);
    t.by    = YW'(by);
    t.cx    = XW'(cx);
    t.cy    = YW'(cy);
    t.xmin  = XW'(min3(ax, bx, cx));
    t.xmax  = XW'(max3(ax, bx, cx));
    t.ymin  = YW'(min3(ay, by, cy));
    t.ymax  = YW'(max3(ay, by, cy));
    t.area2 = AREA_W'(a);
    return t;
  endfunction

  function automatic bit is_culled(tri_t t);
`ifdef TRI_CULL_EN
    return $signed(t.area2) <= 0;
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit due_now();
    return (pend.size() > 0) && (pend[0].due == cyc);
  endfunction

  task automatic model_edge(input bit fs, input bit vv, input int x, input int y, input bit rdy);
    bit    pop;
    bit    was_full;
    pend_t p;
    pop      = (mq.size() > 0) && rdy;
    was_full = (mq.size() >= DEPTH);
    if (fs) begin mcnt = 0; movf = 0; end
    if (pop) void'(mq.pop_front());
    if (due_now()) begin
      p = pend.pop_front();
      if (!is_culled(p.t)) begin
        if (!was_full || pop) begin
          mq.push_back(p.t);
          if (mcnt < 65535) mcnt++;
        end else begin
          movf = 1;
        end
      end
    end
    if (fs) nv = 0;
    if (vv) begin
      vx[nv] = x;
      vy[nv] = y;
      nv++;
      if (nv == 3) begin
        p.t   = make_tri(vx[0], vy[0], vx[1], vy[1], vx[2], vy[2]);
        p.due = cyc + 4;
        pend.push_back(p);
        nv = 0;
      end
    end
    cyc++;
  endtask

  task automatic compare();
    check("valid", tri_valid, mq.size() > 0);
    if (mq.size() > 0) check("head", tri_out, mq[0]);
    check("count", tri_count, mcnt);
    check("ovf", overflow, movf);
  endtask

  task automatic step(input bit fs, input bit vv, input int x, input int y, input bit rdy);
    frame_start = fs;
    vtx_valid   = vv;
    vtx_x       = XW'(x);
    vtx_y       = YW'(y);
    tri_ready   = rdy;
    model_edge(fs, vv, x, y, rdy);
    @(posedge clk_in);
    #1;
    compare();
  endtask

  task automatic tri3(input int ax, input int ay, input int bx, input int by,
                      input int cx, input int cy, input bit rdy);
    step(0, 1, ax, ay, rdy);
    step(0, 1, bx, by, rdy);
    step(0, 1, cx, cy, rdy);
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, rdy);
  endtask

  task automatic apply_reset();
    frame_start = 0;
    vtx_valid   = 0;
    tri_ready   = 0;
    rst_in      = 0;
    #2;
    check("rst_valid", tri_valid, 0);
    check("rst_out", tri_out, 0);
    check("rst_count", tri_count, 0);
    check("rst_ovf", overflow, 0);
    mq.delete();
    pend.delete();
    nv   = 0;
    mcnt = 0;
    movf = 0;
    @(posedge clk_in);
    #1;
    rst_in = 1;
  endtask

  initial begin
    #1;
    apply_reset();

    // Counter-clockwise right triangle
    tri3(0, 0, 10, 0, 0, 10, 0);
    idle(3, 0);
    check("ccw_pre_valid", tri_valid, 0);
    idle(1, 0);
    check("ccw_valid", tri_valid, 1);
    check("ccw_area", $signed(tri_out.area2), 100);
    check("ccw_xmin", tri_out.xmin, 0);
    check("ccw_xmax", tri_out.xmax, 10);
    check("ccw_ymin", tri_out.ymin, 0);
    check("ccw_ymax", tri_out.ymax, 10);
    check("ccw_count", tri_count, 1);
    idle(2, 1);

    // Clockwise and collinear triangles
    tri3(0, 0, 0, 10, 10, 0, 0);
    idle(4, 0);
`ifdef TRI_CULL_EN
    check("cw_culled", tri_valid, 0);
`else
    check("cw_area", $signed(tri_out.area2), -100);
`endif
    idle(2, 1);
    tri3(0, 0, 5, 5, 10, 10, 0);
    idle(4, 0);
`ifdef TRI_CULL_EN
    check("col_culled", tri_valid, 0);
`else
    check("col_area", $signed(tri_out.area2), 0);
`endif
    idle(2, 1);

    // Fill past capacity, then drain
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < DEPTH + 1; i++)
      tri3(0, 0, $urandom_range(1024, 1), 0, 0, $urandom_range(720, 1), 0);
    idle(5, 0);
    check("ovf_count", tri_count, 16);
    check("ovf_flag", overflow, 1);
    idle(DEPTH + 4, 1);

    // Partial triangle discarded by frame_start carrying a vertex
    step(0, 1, 100, 100, 1);
    step(0, 1, 200, 100, 1);
    step(1, 1, 3, 4, 0);
    check("fs_ovf_clr", overflow, 0);
    check("fs_cnt_clr", tri_count, 0);
    step(0, 1, 50, 4, 0);
    step(0, 1, 3, 60, 0);
    idle(5, 0);
    check("fs_one_tri", tri_count, 1);
    check("fs_area", $signed(tri_out.area2), 47 * 56);
    check("fs_ax", tri_out.ax, 3);
    idle(3, 1);

    // Screen extremes
    tri3(1024, 720, 0, 0, 1024, 0, 0);
    idle(4, 0);
    check("ext_area", $signed(tri_out.area2), 737280);
    check("ext_xmax", tri_out.xmax, 1024);
    check("ext_ymax", tri_out.ymax, 720);
    idle(2, 1);

    // Reset while a triangle sits in P2
    tri3(0, 0, 30, 0, 0, 30, 1);
    idle(2, 1);
    apply_reset();
    idle(8, 1);
    check("rst_p2_gone", tri_count, 0);

    // Randomized traffic with varying backpressure
    for (int blk = 0; blk < 6; blk++) begin
      int rdy_pct;
      rdy_pct = (blk % 3 == 0) ? 10 : ((blk % 3 == 1) ? 50 : 95);
      for (int i = 0; i < 500; i++) begin
        bit fs;
        fs = ($urandom_range(199, 0) == 0) && !due_now();
        step(fs, $urandom_range(99, 0) < 80, $urandom_range(1024, 0),
             $urandom_range(720, 0), $urandom_range(99, 0) < rdy_pct);
      end
    end
    idle(DEPTH + 8, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
